// File: rtl/tia_horizontal_motion_generator_pkg.sv
// Shared constants, object indices and state encoding for the TIA horizontal
// motion generator and its per-object comparators.
package tia_horizontal_motion_generator_pkg;

  localparam int HM_WIDTH = 4;
  localparam int HM_STEPS = 16;
  localparam int NUM_OBJ  = 5;

  localparam int OBJ_P0 = 0;
  localparam int OBJ_P1 = 1;
  localparam int OBJ_M0 = 2;
  localparam int OBJ_M1 = 3;
  localparam int OBJ_BL = 4;

  localparam logic [HM_WIDTH-1:0] HM_BIAS   = 4'h8;
  localparam logic [HM_WIDTH-1:0] LAST_STEP = HM_WIDTH'(HM_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } hm_state_e;

  // Two's-complement motion value to unsigned extra-clock count (-8 -> 0, +7 -> 15).
  function automatic logic [HM_WIDTH-1:0] motion_compare(input logic [HM_WIDTH-1:0] hm);
    return hm ^ HM_BIAS;
  endfunction

endpackage

// File: rtl/tia_motion_comparator.sv
// One object's slice of the HMOVE sequence: enable flag, step-vs-motion
// equality compare and the registered active-low extra-clock strobe.
module tia_motion_comparator
  import tia_horizontal_motion_generator_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                step,
  input  logic                last,
  input  logic [HM_WIDTH-1:0] step_cnt,
  input  logic [HM_WIDTH-1:0] hm,
  output logic                ec_bar
);

  logic en_r;
  logic ec_bar_r;
  logic match_s;
  logic pulse_s;

  // Equality only: a late write that drops v below the step never clears en.
  always_comb begin
    match_s = (step_cnt == motion_compare(hm));
    pulse_s = step && en_r && !match_s;
  end

  // Enable flag: armed by HMOVE, cleared on match or after the final step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_r <= 1'b0;
    end else if (start) begin
      en_r <= 1'b1;
    end else if (step && (last || match_s)) begin
      en_r <= 1'b0;
    end else begin
      en_r <= en_r;
    end
  end

  // Registered strobe: low for exactly the cycle after a pulsing step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ec_bar_r <= 1'b1;
    end else begin
      ec_bar_r <= ~pulse_s;
    end
  end

  assign ec_bar = ec_bar_r;

endmodule

// File: rtl/tia_horizontal_motion_generator.sv
// HMOVE sequencer: holds the five motion registers, the 16-step counter and
// the IDLE/ARMED/RUN control, and fans the step out to five comparators.
module tia_horizontal_motion_generator
  import tia_horizontal_motion_generator_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                hm_tick,
  input  logic                hmove,
  input  logic                hmclr,
  input  logic                hmp0_wr,
  input  logic                hmp1_wr,
  input  logic                hmm0_wr,
  input  logic                hmm1_wr,
  input  logic                hmbl_wr,
  input  logic [HM_WIDTH-1:0] d_hi,
  output logic                p0ec_bar,
  output logic                p1ec_bar,
  output logic                m0ec_bar,
  output logic                m1ec_bar,
  output logic                blec_bar,
  output logic                sec
);

  hm_state_e           state_r;
  hm_state_e           next_state_s;
  logic [HM_WIDTH-1:0] s_r;
  logic                sec_r;
  logic [HM_WIDTH-1:0] hm_r [NUM_OBJ];
  logic [NUM_OBJ-1:0]  wr_s;
  logic [NUM_OBJ-1:0]  ec_bar_s;
  logic                start_s;
  logic                step_s;
  logic                last_s;

  assign wr_s = {hmbl_wr, hmm1_wr, hmm0_wr, hmp1_wr, hmp0_wr};

  // Sequencer next state; a tick coincident with hmove is swallowed by the restart.
  always_comb begin
    next_state_s = state_r;
    start_s      = hmove;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hmove) begin
          next_state_s = ST_ARMED;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ARMED, ST_RUN: begin
        if (hmove) begin
          next_state_s = ST_ARMED;
        end else if (hm_tick) begin
          step_s = 1'b1;
          if (s_r == LAST_STEP) begin
            last_s       = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_RUN;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, step counter and sec; sec tracks whether a sequence is live.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      s_r     <= '0;
      sec_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      sec_r   <= (next_state_s != ST_IDLE);
      if (start_s || last_s) begin
        s_r <= '0;
      end else if (step_s) begin
        s_r <= s_r + 1'b1;
      end else begin
        s_r <= s_r;
      end
    end
  end

  // Motion registers; hmclr beats any same-cycle write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        hm_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (hmclr) begin
          hm_r[i] <= '0;
        end else if (wr_s[i]) begin
          hm_r[i] <= d_hi;
        end else begin
          hm_r[i] <= hm_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    tia_motion_comparator u_cmp (
      .clock    (clock),
      .reset    (reset),
      .start    (start_s),
      .step     (step_s),
      .last     (last_s),
      .step_cnt (s_r),
      .hm       (hm_r[g]),
      .ec_bar   (ec_bar_s[g])
    );
  end

  assign p0ec_bar = ec_bar_s[OBJ_P0];
  assign p1ec_bar = ec_bar_s[OBJ_P1];
  assign m0ec_bar = ec_bar_s[OBJ_M0];
  assign m1ec_bar = ec_bar_s[OBJ_M1];
  assign blec_bar = ec_bar_s[OBJ_BL];
  assign sec      = sec_r;

endmodule

// File: tb/tb_tia_horizontal_motion_generator.sv
// Directed bench for the HMOVE generator: counts extra-clock pulses per object
// on the falling clock edge and checks width, latency and sec timing.
module tb_tia_horizontal_motion_generator;

  logic       clock;
  logic       reset;
  logic       hm_tick;
  logic       hmove;
  logic       hmclr;
  logic       hmp0_wr;
  logic       hmp1_wr;
  logic       hmm0_wr;
  logic       hmm1_wr;
  logic       hmbl_wr;
  logic [3:0] d_hi;
  logic       p0ec_bar;
  logic       p1ec_bar;
  logic       m0ec_bar;
  logic       m1ec_bar;
  logic       blec_bar;
  logic       sec;

  int         n_checks;
  int         n_fail;
  int         cnt [5];
  int         width_err;
  int         lat_err;
  logic [4:0] prev_low;
  logic [4:0] mon_ec;
  logic       tick_at_edge;

  tia_horizontal_motion_generator dut (
    .clock    (clock),
    .reset    (reset),
    .hm_tick  (hm_tick),
    .hmove    (hmove),
    .hmclr    (hmclr),
    .hmp0_wr  (hmp0_wr),
    .hmp1_wr  (hmp1_wr),
    .hmm0_wr  (hmm0_wr),
    .hmm1_wr  (hmm1_wr),
    .hmbl_wr  (hmbl_wr),
    .d_hi     (d_hi),
    .p0ec_bar (p0ec_bar),
    .p1ec_bar (p1ec_bar),
    .m0ec_bar (m0ec_bar),
    .m1ec_bar (m1ec_bar),
    .blec_bar (blec_bar),
    .sec      (sec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Remember whether the edge just taken carried a tick.
  always @(posedge clock) tick_at_edge = hm_tick;

  // Pulse monitor: count low cycles, flag wide pulses and pulses not following a tick.
  always @(negedge clock) begin
    mon_ec = {blec_bar, m1ec_bar, m0ec_bar, p1ec_bar, p0ec_bar};
    for (int i = 0; i < 5; i++) begin
      if (!mon_ec[i]) begin
        cnt[i]++;
        if (prev_low[i]) width_err++;
        if (!tick_at_edge) lat_err++;
      end
      prev_low[i] = !mon_ec[i];
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    width_err = 0;
    lat_err   = 0;
    prev_low  = 5'b00000;
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      hm_tick = 1'b1;
      next_cycle();
      hm_tick = 1'b0;
      repeat (3) next_cycle();
    end
  endtask

  task automatic write_hm(input int obj, input logic [3:0] val);
    d_hi = val;
    case (obj)
      0: hmp0_wr = 1'b1;
      1: hmp1_wr = 1'b1;
      2: hmm0_wr = 1'b1;
      3: hmm1_wr = 1'b1;
      default: hmbl_wr = 1'b1;
    endcase
    next_cycle();
    {hmp0_wr, hmp1_wr, hmm0_wr, hmm1_wr, hmbl_wr} = 5'b00000;
    d_hi = 4'h0;
  endtask

  task automatic do_hmove();
    hmove = 1'b1;
    next_cycle();
    hmove = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {hm_tick, hmove, hmclr} = 3'b000;
    {hmp0_wr, hmp1_wr, hmm0_wr, hmm1_wr, hmbl_wr} = 5'b00000;
    d_hi = 4'h0;
    clear_counts();
    repeat (2) next_cycle();
    reset = 1'b0;
    next_cycle();
    mon_ec = {blec_bar, m1ec_bar, m0ec_bar, p1ec_bar, p0ec_bar};
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (mon_ec[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ec_bar[%0d]: got %b expected 1", i, mon_ec[i]);
      end
    end
    n_checks++;
    if (sec !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sec: got %b expected 0", sec);
    end
  endtask

  task automatic test_zero_motion();
    write_hm(2, 4'h0);
    clear_counts();
    do_hmove();
    n_checks++;
    if (sec !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_sec_armed: got %b expected 1", sec);
    end
    do_ticks(15);
    hm_tick = 1'b1;
    n_checks++;
    if (sec !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_sec_before_last: got %b expected 1", sec);
    end
    next_cycle();
    hm_tick = 1'b0;
    n_checks++;
    if (sec !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_sec_after_last: got %b expected 0", sec);
    end
    repeat (3) next_cycle();
    n_checks++;
    if (cnt[2] !== 8) begin
      n_fail++;
      $display("FAIL zero_m0_pulses: got %0d expected 8", cnt[2]);
    end
  endtask

  task automatic test_extremes();
    write_hm(0, 4'h7);
    write_hm(4, 4'h8);
    clear_counts();
    do_hmove();
    do_ticks(16);
    n_checks++;
    if (cnt[0] !== 15) begin
      n_fail++;
      $display("FAIL ext_p0_pulses: got %0d expected 15", cnt[0]);
    end
    n_checks++;
    if (cnt[4] !== 0) begin
      n_fail++;
      $display("FAIL ext_bl_pulses: got %0d expected 0", cnt[4]);
    end
    n_checks++;
    if (cnt[1] !== 8) begin
      n_fail++;
      $display("FAIL ext_p1_pulses: got %0d expected 8", cnt[1]);
    end
    n_checks++;
    if (width_err !== 0) begin
      n_fail++;
      $display("FAIL ext_pulse_width: got %0d wide pulses expected 0", width_err);
    end
    n_checks++;
    if (lat_err !== 0) begin
      n_fail++;
      $display("FAIL ext_pulse_latency: got %0d untimely pulses expected 0", lat_err);
    end
  endtask

  task automatic test_late_write();
    write_hm(3, 4'h7);
    clear_counts();
    do_hmove();
    do_ticks(11);
    write_hm(3, 4'hC);
    do_ticks(5);
    n_checks++;
    if (cnt[3] !== 16) begin
      n_fail++;
      $display("FAIL late_m1_pulses: got %0d expected 16", cnt[3]);
    end
    n_checks++;
    if (sec !== 1'b0) begin
      n_fail++;
      $display("FAIL late_sec_end: got %b expected 0", sec);
    end
  endtask

  task automatic test_back_to_back();
    write_hm(1, 4'h7);
    clear_counts();
    do_hmove();
    do_ticks(5);
    n_checks++;
    if (cnt[1] !== 5) begin
      n_fail++;
      $display("FAIL b2b_p1_first: got %0d expected 5", cnt[1]);
    end
    do_hmove();
    n_checks++;
    if (sec !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_sec_restart: got %b expected 1", sec);
    end
    do_ticks(16);
    n_checks++;
    if (cnt[1] !== 20) begin
      n_fail++;
      $display("FAIL b2b_p1_total: got %0d expected 20", cnt[1]);
    end
    n_checks++;
    if (width_err !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulse_width: got %0d wide pulses expected 0", width_err);
    end
  endtask

  task automatic test_coincident_tick();
    hmclr   = 1'b1;
    hmp0_wr = 1'b1;
    d_hi    = 4'h7;
    next_cycle();
    hmclr   = 1'b0;
    hmp0_wr = 1'b0;
    d_hi    = 4'h0;
    clear_counts();
    hmove   = 1'b1;
    hm_tick = 1'b1;
    next_cycle();
    hmove   = 1'b0;
    hm_tick = 1'b0;
    repeat (3) next_cycle();
    do_ticks(15);
    n_checks++;
    if (sec !== 1'b1) begin
      n_fail++;
      $display("FAIL coin_sec_after15: got %b expected 1", sec);
    end
    n_checks++;
    if (cnt[0] !== 8) begin
      n_fail++;
      $display("FAIL coin_p0_pulses_hmclr_wins: got %0d expected 8", cnt[0]);
    end
    n_checks++;
    if (cnt[4] !== 8) begin
      n_fail++;
      $display("FAIL coin_bl_pulses: got %0d expected 8", cnt[4]);
    end
    do_ticks(1);
    n_checks++;
    if (sec !== 1'b0) begin
      n_fail++;
      $display("FAIL coin_sec_after16: got %b expected 0", sec);
    end
  endtask

  task automatic test_async_reset();
    write_hm(4, 4'h7);
    clear_counts();
    do_hmove();
    do_ticks(3);
    hm_tick = 1'b1;
    next_cycle();
    hm_tick = 1'b0;
    n_checks++;
    if (blec_bar !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_bl_step3_pulse: got %b expected 0", blec_bar);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (blec_bar !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_bl_immediate: got %b expected 1", blec_bar);
    end
    n_checks++;
    if (sec !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_sec_immediate: got %b expected 0", sec);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
    clear_counts();
    do_ticks(4);
    n_checks++;
    if ((cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4]) !== 0) begin
      n_fail++;
      $display("FAIL rst_idle_ticks: got %0d pulses expected 0",
               cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4]);
    end
    n_checks++;
    if (sec !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle_sec: got %b expected 0", sec);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero_motion();
    test_extremes();
    test_late_write();
    test_back_to_back();
    test_coincident_tick();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
